hmc_bitslip_ctrl: RTL
=====================

Name: hmc_bitslip_ctrl

Overview:
- Per-lane word-alignment sequencer for the deserializer bank that feeds the HMC link controller.
- During link training it watches each lane's deserialized word for the training alignment pattern and issues single-cycle phy_bit_slip pulses, with hold-off between pulses, until the pattern is seen in place.
- It then reports per-lane lock or failure, plus aggregate status, to link training and the register file.

Parameters:
- NUM_LANES, 16: number of serial lanes (8 or 16).
- LANE_WIDTH, 32: deserialized bits per lane per clk_hmc cycle.
- PATTERN_WIDTH, 16: compared bits, taken from lane word bits [PATTERN_WIDTH-1:0]; must be <= LANE_WIDTH.
- ALIGN_PATTERN, 16'hC0F0: expected training pattern.
- HOLDOFF, 8: cycles waited after a slip before re-checking (covers deserializer latency); must be >= 1.
- MATCH_CNT, 4: consecutive matching words required for lock; must be >= 1.
- MAX_SLIPS, 2*LANE_WIDTH: slip budget per lane before the lane fails.

Ports:
- clk_hmc  in  1  link clock.
- res_n  in  1  reset.
- enable  in  1  training active; level-sensitive.
- from_deserializers  in  NUM_LANES*LANE_WIDTH  lane words; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- phy_bit_slip  out  NUM_LANES  one-cycle slip pulse per lane.
- lane_locked  out  NUM_LANES  lane aligned.
- lane_fail  out  NUM_LANES  slip budget exhausted.
- lane_polarity  out  NUM_LANES  lane detected inverted (optional feature).
- all_locked  out  1  registered AND of lane_locked.
- any_fail  out  1  registered OR of lane_fail.

Interface (already decided): one clock, clk_hmc; reset res_n is asynchronous and active-low.

Behaviour:
- Reset: all outputs 0; every lane in IDLE; all counters 0.
- Lanes are fully independent; there is one FSM per lane.
- All outputs are registered. all_locked and any_fail lag the per-lane flags by 1 cycle.
- Per-lane states: IDLE, CHECK, SLIP, HOLD, LOCKED, FAIL.
- IDLE:
  - Clear slip_cnt and match_cnt.
  - If enable=1, go to CHECK.
- CHECK: sample the word every cycle.
  - On a match, increment match_cnt. When the match brings match_cnt to MATCH_CNT, go to LOCKED.
  - On a mismatch, clear match_cnt. If slip_cnt==MAX_SLIPS, go to FAIL; otherwise go to SLIP.
- SLIP:
  - phy_bit_slip[i]=1 for exactly this cycle.
  - Increment slip_cnt, then go to HOLD.
- HOLD:
  - Count HOLDOFF cycles, then go to CHECK with match_cnt=0.
  - No data is compared during HOLD.
- LOCKED:
  - lane_locked=1.
  - Data is ignored (the pattern stops after training); the state is held.
- FAIL:
  - lane_fail=1; the state is held.
- enable=0 in any state forces IDLE on the next edge:
  - clears lane_locked, lane_fail, lane_polarity and counters;
  - a phy_bit_slip pulse in flight still completes its single cycle and is never extended.
  - Re-asserting enable restarts the search from slip_cnt=0.
- Slip cadence while misaligned: SLIP + HOLDOFF cycles + 1 CHECK cycle, giving pulses exactly HOLDOFF+2 cycles apart.
- Lock latency after entering CHECK with aligned data: MATCH_CNT cycles.
- Counter widths: slip_cnt is $clog2(MAX_SLIPS+1) bits, hold counter $clog2(HOLDOFF+1) bits, match_cnt $clog2(MATCH_CNT+1) bits. No counter ever wraps.
- At most MAX_SLIPS pulses are issued per enable session.

Optional Feature:
- Macro: HMC_BITSLIP_POLARITY_DETECT_EN.
- With the macro: CHECK also compares against ~ALIGN_PATTERN with a separate inverted-match counter.
  - MATCH_CNT consecutive inverted matches go to LOCKED and set lane_polarity[i]=1.
  - A word matching neither pattern clears both counters.
- Without the macro: lane_polarity is tied to 0, and an inverted pattern counts as a mismatch, so the lane ends in FAIL.

Decomposition:
- Package hmc_bitslip_pkg holds:
  - typedef enum bitslip_state_t {IDLE, CHECK, SLIP, HOLD, LOCKED, FAIL};
  - default constants for pattern, hold-off and match count.
- Sub-module hmc_bitslip_lane holds one lane's FSM and counters. The top generates NUM_LANES instances and registers all_locked and any_fail.

Test Plan (default parameters):
- Aligned data on all 16 lanes, enable rises → zero slip pulses; lane_locked=16'hFFFF 4 cycles after CHECK entry; all_locked 1 cycle later.
- Lane 5 offset by 3 bits (bench deserializer model rotates on slip) → exactly 3 pulses on phy_bit_slip[5], spaced 10 cycles apart; lane 5 locks; other lanes see no pulses.
- Lane 2 fed constant 0 → 64 pulses, then lane_fail[2]=1 and any_fail=1; no 65th pulse; all_locked stays 0.
- enable dropped during HOLD of lane 7, then re-asserted → lane 7 returns to IDLE with outputs 0; the new search starts slip_cnt at 0 and locks normally.
- res_n asserted mid-slip → phy_bit_slip, lane_locked and lane_fail go to 0 immediately (asynchronously).
- With HMC_BITSLIP_POLARITY_DETECT_EN, lane 0 fed 16'h3F0F aligned → lane_locked[0]=1, lane_polarity[0]=1, zero slips. Without the macro, the same stimulus gives lane_fail[0]=1 after 64 slips.

Source files
------------

// File: rtl/hmc_bitslip_pkg.sv
// Shared types and default constants for the HMC deserializer word-alignment sequencer.
package hmc_bitslip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SLIP,
    HOLD,
    LOCKED,
    FAIL
  } bitslip_state_t;

  localparam logic [15:0] DEFAULT_ALIGN_PATTERN = 16'hC0F0;
  localparam int          DEFAULT_HOLDOFF       = 8;
  localparam int          DEFAULT_MATCH_CNT     = 4;

endpackage

// File: rtl/hmc_bitslip_lane.sv
// One lane's alignment FSM: checks the word, pulses bit-slip with hold-off, reports lock/fail.
// Inverted-pattern detection is built in when HMC_BITSLIP_POLARITY_DETECT_EN is defined.
module hmc_bitslip_lane
  import hmc_bitslip_pkg::*;
#(
  parameter int                       LANE_WIDTH    = 32,
  parameter int                       PATTERN_WIDTH = 16,
  parameter logic [PATTERN_WIDTH-1:0] ALIGN_PATTERN = PATTERN_WIDTH'(DEFAULT_ALIGN_PATTERN),
  parameter int                       HOLDOFF       = DEFAULT_HOLDOFF,
  parameter int                       MATCH_CNT     = DEFAULT_MATCH_CNT,
  parameter int                       MAX_SLIPS     = 2 * LANE_WIDTH
) (
  input  logic                  clk_hmc,
  input  logic                  res_n,
  input  logic                  enable,
  input  logic [LANE_WIDTH-1:0] lane_word,
  output logic                  bit_slip,
  output logic                  locked,
  output logic                  fail,
  output logic                  polarity
);

  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int HOLD_W  = $clog2(HOLDOFF + 1);
  localparam int MATCH_W = $clog2(MATCH_CNT + 1);

  bitslip_state_t     state_q, state_d;
  logic [SLIP_W-1:0]  slip_cnt_q, slip_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [MATCH_W-1:0] inv_cnt_q, inv_cnt_d;
  logic               slip_q, slip_d, locked_q, locked_d, fail_q, fail_d, pol_q, pol_d;

  logic is_match, is_inv, match_last, inv_last, hold_last, budget_spent;

  if (LANE_WIDTH > PATTERN_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^lane_word[LANE_WIDTH-1:PATTERN_WIDTH];
  end

  assign is_match = (lane_word[PATTERN_WIDTH-1:0] == ALIGN_PATTERN);
`ifdef HMC_BITSLIP_POLARITY_DETECT_EN
  assign is_inv   = (lane_word[PATTERN_WIDTH-1:0] == ~ALIGN_PATTERN);
`else
  assign is_inv   = 1'b0;
`endif

  assign match_last   = (match_cnt_q == MATCH_W'(MATCH_CNT - 1));
  assign inv_last     = (inv_cnt_q == MATCH_W'(MATCH_CNT - 1));
  assign hold_last    = (hold_cnt_q == HOLD_W'(HOLDOFF - 1));
  assign budget_spent = (slip_cnt_q == SLIP_W'(MAX_SLIPS));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_hmc or negedge res_n) begin
    if (!res_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = CHECK;
        CHECK: begin
          if ((is_match && match_last) || (is_inv && inv_last)) state_d = LOCKED;
          else if (!is_match && !is_inv) state_d = budget_spent ? FAIL : SLIP;
        end
        SLIP:  state_d = HOLD;
        HOLD:  if (hold_last) state_d = CHECK;
        default: ;
      endcase
    end
  end

  always_comb begin
    slip_cnt_d  = slip_cnt_q;
    match_cnt_d = match_cnt_q;
    inv_cnt_d   = inv_cnt_q;
    hold_cnt_d  = '0;
    if (!enable || state_q == IDLE) begin
      slip_cnt_d  = '0;
      match_cnt_d = '0;
      inv_cnt_d   = '0;
    end else begin
      unique case (state_q)
        CHECK: begin
          match_cnt_d = is_match ? match_cnt_q + MATCH_W'(1) : '0;
          inv_cnt_d   = is_inv ? inv_cnt_q + MATCH_W'(1) : '0;
        end
        SLIP:  slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        HOLD:  hold_cnt_d = hold_last ? '0 : hold_cnt_q + HOLD_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    slip_d   = (state_d == SLIP);
    locked_d = (state_d == LOCKED);
    fail_d   = (state_d == FAIL);
    pol_d    = (state_d == LOCKED) && (pol_q || (state_q == CHECK && is_inv));
  end

  always_ff @(posedge clk_hmc or negedge res_n) begin
    if (!res_n) begin
      slip_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      match_cnt_q <= '0;
      inv_cnt_q   <= '0;
      slip_q      <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      pol_q       <= 1'b0;
    end else begin
      slip_cnt_q  <= slip_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      match_cnt_q <= match_cnt_d;
      inv_cnt_q   <= inv_cnt_d;
      slip_q      <= slip_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      pol_q       <= pol_d;
    end
  end

  assign bit_slip = slip_q;
  assign locked   = locked_q;
  assign fail     = fail_q;
  assign polarity = pol_q;

endmodule

// File: rtl/hmc_bitslip_ctrl.sv
// Per-lane bit-slip alignment sequencer for the HMC deserializer bank, with aggregate status.
// Optional inverted-lane detection: define HMC_BITSLIP_POLARITY_DETECT_EN.
module hmc_bitslip_ctrl
  import hmc_bitslip_pkg::*;
#(
  parameter int                       NUM_LANES     = 16,
  parameter int                       LANE_WIDTH    = 32,
  parameter int                       PATTERN_WIDTH = 16,
  parameter logic [PATTERN_WIDTH-1:0] ALIGN_PATTERN = PATTERN_WIDTH'(DEFAULT_ALIGN_PATTERN),
  parameter int                       HOLDOFF       = DEFAULT_HOLDOFF,
  parameter int                       MATCH_CNT     = DEFAULT_MATCH_CNT,
  parameter int                       MAX_SLIPS     = 2 * LANE_WIDTH
) (
  input  logic                            clk_hmc,
  input  logic                            res_n,
  input  logic                            enable,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] from_deserializers,
  output logic [NUM_LANES-1:0]            phy_bit_slip,
  output logic [NUM_LANES-1:0]            lane_locked,
  output logic [NUM_LANES-1:0]            lane_fail,
  output logic [NUM_LANES-1:0]            lane_polarity,
  output logic                            all_locked,
  output logic                            any_fail
);

  logic all_locked_q, any_fail_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    hmc_bitslip_lane #(
      .LANE_WIDTH   (LANE_WIDTH),
      .PATTERN_WIDTH(PATTERN_WIDTH),
      .ALIGN_PATTERN(ALIGN_PATTERN),
      .HOLDOFF      (HOLDOFF),
      .MATCH_CNT    (MATCH_CNT),
      .MAX_SLIPS    (MAX_SLIPS)
    ) u_lane (
      .clk_hmc  (clk_hmc),
      .res_n    (res_n),
      .enable   (enable),
      .lane_word(from_deserializers[g*LANE_WIDTH +: LANE_WIDTH]),
      .bit_slip (phy_bit_slip[g]),
      .locked   (lane_locked[g]),
      .fail     (lane_fail[g]),
      .polarity (lane_polarity[g])
    );
  end

  // Aggregates are taken from the registered lane flags, so they trail them by one cycle.
  always_ff @(posedge clk_hmc or negedge res_n) begin
    if (!res_n) begin
      all_locked_q <= 1'b0;
      any_fail_q   <= 1'b0;
    end else begin
      all_locked_q <= &lane_locked;
      any_fail_q   <= |lane_fail;
    end
  end

  assign all_locked = all_locked_q;
  assign any_fail   = any_fail_q;

endmodule
